// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter
//   Two-port round-robin arbiter/sequencer that is the sole master of a
//   single-port RAM with registered read data. Each requester holds req with a
//   stable command until it sees a one-cycle gnt. The block then drives exactly
//   one RAM strobe for one cycle. For a read, the RAM data is returned to the
//   winning port together with a one-cycle rvalid pulse.
//
// Ports
//   clk, rstn                        clock (posedge), asynchronous active-low reset
//   pN_req/pN_wr/pN_addr/pN_wdata    port N command (N = 0, 1)
//   pN_gnt                           1-cycle pulse: port N command accepted
//   pN_rvalid/pN_rdata               read return; rdata holds until the next port N read
//   ram_we/ram_re/ram_addr/ram_data_in   RAM strobes, address and write data
//   ram_data_out                     RAM read data, valid the cycle after ram_re is sampled
//   busy                             high whenever the sequencer is not IDLE
module ram_rr_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  state_t                state, state_nxt;
  logic                  last_q, last_nxt;   // port granted most recently
  logic                  win_q, win_nxt;     // port owning the access in flight
  logic                  sel;
  logic                  p0_gnt_nxt, p1_gnt_nxt;
  logic                  p0_rvalid_nxt, p1_rvalid_nxt;
  logic [DATA_WIDTH-1:0] p0_rdata_nxt, p1_rdata_nxt;
  logic                  ram_we_nxt, ram_re_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_nxt;
  logic [DATA_WIDTH-1:0] ram_data_in_nxt;

  always_comb begin
    state_nxt       = state;
    last_nxt        = last_q;
    win_nxt         = win_q;
    sel             = 1'b0;
    p0_gnt_nxt      = 1'b0;
    p1_gnt_nxt      = 1'b0;
    p0_rvalid_nxt   = 1'b0;
    p1_rvalid_nxt   = 1'b0;
    p0_rdata_nxt    = p0_rdata;
    p1_rdata_nxt    = p1_rdata;
    ram_we_nxt      = 1'b0;
    ram_re_nxt      = 1'b0;
    ram_addr_nxt    = ram_addr;
    ram_data_in_nxt = ram_data_in;

    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          // Under contention the port that did not win last time goes first.
          sel             = (p0_req && p1_req) ? ~last_q : p1_req;
          win_nxt         = sel;
          last_nxt        = sel;
          p0_gnt_nxt      = ~sel;
          p1_gnt_nxt      = sel;
          ram_we_nxt      = sel ? p1_wr : p0_wr;
          ram_re_nxt      = sel ? ~p1_wr : ~p0_wr;
          ram_addr_nxt    = sel ? p1_addr : p0_addr;
          ram_data_in_nxt = sel ? p1_wdata : p0_wdata;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        // The strobes are registered, so ram_we still tells which command is in flight.
        state_nxt = ram_we ? IDLE : RD_WAIT;
      end
      RD_WAIT: begin
        if (win_q) begin
          p1_rdata_nxt  = ram_data_out;
          p1_rvalid_nxt = 1'b1;
        end else begin
          p0_rdata_nxt  = ram_data_out;
          p0_rvalid_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      p0_gnt      <= 1'b0;
      p1_gnt      <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      ram_we      <= 1'b0;
      ram_re      <= 1'b0;
      ram_addr    <= '0;
      ram_data_in <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_q      <= last_nxt;
      win_q       <= win_nxt;
      p0_gnt      <= p0_gnt_nxt;
      p1_gnt      <= p1_gnt_nxt;
      p0_rvalid   <= p0_rvalid_nxt;
      p1_rvalid   <= p1_rvalid_nxt;
      p0_rdata    <= p0_rdata_nxt;
      p1_rdata    <= p1_rdata_nxt;
      ram_we      <= ram_we_nxt;
      ram_re      <= ram_re_nxt;
      ram_addr    <= ram_addr_nxt;
      ram_data_in <= ram_data_in_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter
//   Drives both requester ports from command queues, emulates the registered
//   16x8 RAM, and predicts grants, strobes, read returns and busy from the
//   arbitration rules: who wins, how many cycles each access occupies, and
//   what memory holds.
module tb_ram_rr_arbiter;

  typedef struct packed {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       p0_req = 1'b0, p0_wr = 1'b0;
  logic [3:0] p0_addr = '0;
  logic [7:0] p0_wdata = '0;
  logic       p1_req = 1'b0, p1_wr = 1'b0;
  logic [3:0] p1_addr = '0;
  logic [7:0] p1_wdata = '0;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       ram_we, ram_re, busy;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out = '0;
  logic [7:0] ram_mem [16];

  int total = 0;
  int bad   = 0;

  // reference model state
  cmd_t       q0[$], q1[$];
  int         glog[$];
  logic [7:0] mdl_mem [16];
  logic [7:0] exp_rd [2];
  logic [7:0] rvd [2];
  int         rvc [2];
  bit         pend [2];
  int         blk;
  int         exp_last;

  ram_rr_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data_in;
    if (ram_re) ram_data_out <= ram_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_p0_gnt"}, 32'(p0_gnt), 0);
    chk({tag, "_p1_gnt"}, 32'(p1_gnt), 0);
    chk({tag, "_p0_rvalid"}, 32'(p0_rvalid), 0);
    chk({tag, "_p1_rvalid"}, 32'(p1_rvalid), 0);
    chk({tag, "_p0_rdata"}, 32'(p0_rdata), 0);
    chk({tag, "_p1_rdata"}, 32'(p1_rdata), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_re"}, 32'(ram_re), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_din"}, 32'(ram_data_in), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    exp_last  = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rvc[0] = 0; rvc[1] = 0;
    pend[0] = 0; pend[1] = 0;
    blk = 0;
  endtask

  task automatic drive_port(input int p);
    if (p == 0) begin
      if (q0.size() > 0) begin
        p0_req = 1'b1; p0_wr = q0[0].wr; p0_addr = q0[0].addr; p0_wdata = q0[0].data;
      end else p0_req = 1'b0;
    end else begin
      if (q1.size() > 0) begin
        p1_req = 1'b1; p1_wr = q1[0].wr; p1_addr = q1[0].addr; p1_wdata = q1[0].data;
      end else p1_req = 1'b0;
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [3:0] a, input logic [7:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.data = d;
    return c;
  endfunction

  // Serve both queues to completion; called right after a falling edge.
  task automatic run(input int budget);
    int   cyc = 0;
    int   w;
    bit   exp_any;
    bit   exp_rv [2];
    bit   pend_now [2];
    cmd_t c;
    glog.delete();
    drive_port(0);
    drive_port(1);
    while (cyc < budget && !(q0.size() == 0 && q1.size() == 0 && blk == 0 &&
                             rvc[0] == 0 && rvc[1] == 0 && !pend[0] && !pend[1])) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = 0;
        if (rvc[p] > 0) begin
          rvc[p]--;
          if (rvc[p] == 0) begin
            exp_rv[p] = 1;
            exp_rd[p] = rvd[p];
          end
        end
      end
      chk("p0_rvalid", 32'(p0_rvalid), 32'(exp_rv[0]));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(exp_rv[1]));
      chk("p0_rdata", 32'(p0_rdata), 32'(exp_rd[0]));
      chk("p1_rdata", 32'(p1_rdata), 32'(exp_rd[1]));
      pend_now[0] = pend[0];
      pend_now[1] = pend[1];
      exp_any = (blk == 0) && (p0_req || p1_req);
      chk("gnt_any", 32'(p0_gnt | p1_gnt), 32'(exp_any));
      if (exp_any) begin
        w = (p0_req && p1_req) ? 1 - exp_last : (p1_req ? 1 : 0);
        exp_last = w;
        if (w == 1) c = (q1.size() > 0) ? q1[0] : '0;
        else        c = (q0.size() > 0) ? q0[0] : '0;
        chk("p0_gnt", 32'(p0_gnt), 32'(w == 0));
        chk("p1_gnt", 32'(p1_gnt), 32'(w == 1));
        chk("ram_we", 32'(ram_we), 32'(c.wr));
        chk("ram_re", 32'(ram_re), 32'(!c.wr));
        chk("ram_addr", 32'(ram_addr), 32'(c.addr));
        if (c.wr) begin
          chk("ram_din", 32'(ram_data_in), 32'(c.data));
          mdl_mem[c.addr] = c.data;
          blk = 1;
        end else begin
          rvc[w] = 2;
          rvd[w] = mdl_mem[c.addr];
          blk = 2;
        end
        glog.push_back(w);
        pend[w] = 1;
      end else begin
        if (blk > 0) blk--;
        chk("ram_we_idle", 32'(ram_we), 0);
        chk("ram_re_idle", 32'(ram_re), 0);
      end
      chk("busy", 32'(busy), 32'(blk > 0));
      // command changes only after the edge that followed the grant
      if (pend_now[0]) begin void'(q0.pop_front()); pend[0] = 0; drive_port(0); end
      if (pend_now[1]) begin void'(q1.pop_front()); pend[1] = 0; drive_port(1); end
    end
    if (cyc >= budget) chk("run_timeout", 0, 1);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    rstn = 1'b1;

    // fill memory through port 1 so every location has known contents
    for (int i = 0; i < 16; i++) q1.push_back(mk(1'b1, 4'(i), 8'($urandom_range(0, 255))));
    q1.push_back(mk(1'b1, 4'd5, 8'h11));
    q1.push_back(mk(1'b1, 4'd10, 8'h33));
    run(200);

    // simultaneous reads: port 0 first, then port 1
    q0.push_back(mk(1'b0, 4'd5, 8'h00));
    q1.push_back(mk(1'b0, 4'd10, 8'h00));
    run(50);
    chk("t3_order_len", 32'(glog.size()), 2);
    if (glog.size() == 2) begin
      chk("t3_first", 32'(glog[0]), 0);
      chk("t3_second", 32'(glog[1]), 1);
    end
    chk("t3_p0_rdata", 32'(p0_rdata), 32'h11);
    chk("t3_p1_rdata", 32'(p1_rdata), 32'h33);

    // port 0 write then read back
    q0.push_back(mk(1'b1, 4'd2, 8'hAA));
    q0.push_back(mk(1'b0, 4'd2, 8'h00));
    run(50);
    chk("t2_p0_rdata", 32'(p0_rdata), 32'hAA);

    // six back-to-back writes per port: grants must alternate
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(1'b1, 4'(i < 2 ? i : i + 1 + (i > 3 ? 1 : 0)), 8'($urandom_range(0, 255))));
      q1.push_back(mk(1'b1, 4'(8 + i + (i > 2 ? 1 : 0)), 8'($urandom_range(0, 255))));
    end
    run(100);
    chk("t4_count", 32'(glog.size()), 12);
    for (int i = 1; i < glog.size(); i++) chk("t4_alternate", 32'(glog[i] != glog[i-1]), 1);

    // cross-port: p1 writes addr 15, p0 reads it
    q1.push_back(mk(1'b1, 4'd15, 8'hFF));
    run(50);
    q0.push_back(mk(1'b0, 4'd15, 8'h00));
    run(50);
    chk("t5_p0_rdata", 32'(p0_rdata), 32'hFF);
    chk("t5_p1_rdata", 32'(p1_rdata), 32'h33);

    // reset while a port 0 read waits for data
    p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 4'd2; p0_wdata = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p0_gnt) break;
    end
    chk("t6_gnt", 32'(p0_gnt), 1);
    @(negedge clk);
    chk("t6_busy_rdwait", 32'(busy), 1);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("t6rst");
    p0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rvalid", 32'(p0_rvalid), 0);
      chk("t6_rdata_zero", 32'(p0_rdata), 0);
    end
    rstn = 1'b1;
    model_reset();
    q0.push_back(mk(1'b0, 4'd2, 8'h00));
    run(50);
    chk("t6_after_rdata", 32'(p0_rdata), 32'hAA);

    // randomized mixed traffic
    for (int r = 0; r < 30; r++) begin
      int n0 = $urandom_range(0, 3);
      int n1 = $urandom_range(0, 3);
      for (int i = 0; i < n0; i++)
        q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
      for (int i = 0; i < n1; i++)
        q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))));
      run(200);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < 16; i++) ram_mem[i] = '0;
  end

endmodule
